// File: rtl/vit_pkg.sv
// Types, FSM state codes and default frame geometry shared by the ViT patch pipeline blocks.
package vit_pkg;

    localparam int DEF_CHANNEL_SIZE    = 8;
    localparam int DEF_NUM_CHANNELS    = 3;
    localparam int DEF_PIXEL_WIDTH     = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
    localparam int DEF_IMG_WIDTH       = 16;
    localparam int DEF_IMG_HEIGHT      = 16;
    localparam int DEF_PATCH_SIZE      = 4;
    localparam int DEF_PATCH_SIZE_LOG2 = 2;

    typedef logic [2:0] state_t;
    typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

    localparam state_t IDLE = 3'b000;
    localparam state_t FILL = 3'b001;
    localparam state_t DONE = 3'b010;

    // Index width that never collapses to zero bits for degenerate geometries.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/unpatchifier_if.sv
// Pixel stream into the unpatchifier: one pixel per accepted beat.
interface unpatchifier_if #(
    parameter int PIXEL_WIDTH = vit_pkg::DEF_PIXEL_WIDTH
) ();

    // A beat transfers on a rising edge where pix_valid && pix_ready are both high.
    // pix_data must be stable whenever pix_valid is high; pix_ready never depends on pix_valid.
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PIXEL_WIDTH-1:0] pix_data;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );

endinterface

// File: rtl/patch_addr_gen.sv
// Patch/position counters and their mapping to raster (x, y); advances once per accept strobe.
module patch_addr_gen
    import vit_pkg::*;
#(
    parameter int IMG_WIDTH         = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT        = DEF_IMG_HEIGHT,
    parameter int PATCH_SIZE        = DEF_PATCH_SIZE,
    parameter int PATCH_SIZE_LOG2   = DEF_PATCH_SIZE_LOG2,
    parameter int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE,
    parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
    localparam int X_W              = clog2_min1(IMG_WIDTH),
    localparam int Y_W              = clog2_min1(IMG_HEIGHT)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam int POS_W    = clog2_min1(PATCH_VECTOR_SIZE);
    localparam int PATCH_W  = clog2_min1(TOTAL_NUM_PATCHES);
    localparam int PIR_LOG2 = $clog2(PATCHES_IN_ROW);

    logic [POS_W-1:0]   pos_idx;
    logic [PATCH_W-1:0] patch_idx;
    logic               pos_last;
    logic               patch_last;

    assign pos_last   = (pos_idx == POS_W'(PATCH_VECTOR_SIZE - 1));
    assign patch_last = (patch_idx == PATCH_W'(TOTAL_NUM_PATCHES - 1));
    assign last       = pos_last && patch_last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pos_idx   <= '0;
            patch_idx <= '0;
        end else if (advance) begin
            if (pos_last) begin
                pos_idx   <= '0;
                patch_idx <= patch_last ? '0 : patch_idx + 1'b1;
            end else begin
                pos_idx <= pos_idx + 1'b1;
            end
        end
    end

    // Patch grid coordinates (prow, pcol) and in-patch offsets (pr, pc), widened for the multiply.
    logic [31:0] prow;
    logic [31:0] pcol;
    logic [31:0] pr;
    logic [31:0] pc;

    assign prow = 32'(patch_idx) >> PIR_LOG2;
    assign pcol = 32'(patch_idx) & 32'(PATCHES_IN_ROW - 1);
    assign pr   = 32'(pos_idx) >> PATCH_SIZE_LOG2;
    assign pc   = 32'(pos_idx) & 32'(PATCH_SIZE - 1);

    assign x = X_W'(pcol * 32'(PATCH_SIZE) + pc);
    assign y = Y_W'(prow * 32'(PATCH_SIZE) + pr);

endmodule

// File: rtl/unpatchifier.sv
// Reassembles a patch-ordered pixel stream into a raster frame buffer image_out[x][y].
// Build option UNPATCHIFIER_CLEAR_ON_TAKE_EN: wipe image_out when the frame is taken.
module unpatchifier
    import vit_pkg::*;
#(
    parameter int CHANNEL_SIZE      = DEF_CHANNEL_SIZE,
    parameter int NUM_CHANNELS      = DEF_NUM_CHANNELS,
    parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int IMG_WIDTH         = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT        = DEF_IMG_HEIGHT,
    parameter int PATCH_SIZE        = DEF_PATCH_SIZE,
    parameter int PATCH_SIZE_LOG2   = DEF_PATCH_SIZE_LOG2,
    parameter int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE,
    parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   output_taken,
    unpatchifier_if.slave          pix,
    output logic [2:0]             state,
    output logic                   done,
    output logic [PIXEL_WIDTH-1:0] image_out [IMG_WIDTH][IMG_HEIGHT]
);

    localparam int X_W = clog2_min1(IMG_WIDTH);
    localparam int Y_W = clog2_min1(IMG_HEIGHT);

    state_t         state_q;
    state_t         state_d;
    logic           accept;
    logic           last;
    logic [X_W-1:0] wr_x;
    logic [Y_W-1:0] wr_y;

    assign pix.pix_ready = (state_q == FILL);
    assign accept        = pix.pix_valid && pix.pix_ready;
    assign state         = state_q;
    assign done          = (state_q == DONE);

    // Counters are held at zero outside FILL so every frame starts at patch 0, position 0.
    patch_addr_gen #(
        .IMG_WIDTH         (IMG_WIDTH),
        .IMG_HEIGHT        (IMG_HEIGHT),
        .PATCH_SIZE        (PATCH_SIZE),
        .PATCH_SIZE_LOG2   (PATCH_SIZE_LOG2),
        .PATCHES_IN_ROW    (PATCHES_IN_ROW),
        .TOTAL_NUM_PATCHES (TOTAL_NUM_PATCHES),
        .PATCH_VECTOR_SIZE (PATCH_VECTOR_SIZE)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != FILL),
        .advance (accept),
        .x       (wr_x),
        .y       (wr_y),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = FILL;
            FILL:    if (accept && last) state_d = DONE;
            DONE:    if (output_taken) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                for (int j = 0; j < IMG_HEIGHT; j++) begin
                    image_out[i][j] <= '0;
                end
            end
`ifdef UNPATCHIFIER_CLEAR_ON_TAKE_EN
        end else if (state_q == DONE && output_taken) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                for (int j = 0; j < IMG_HEIGHT; j++) begin
                    image_out[i][j] <= '0;
                end
            end
`endif
        end else if (accept) begin
            image_out[wr_x][wr_y] <= pix.pix_data;
        end
    end

endmodule

// File: tb/tb_unpatchifier.sv
// Bench for unpatchifier: ramp, back-pressure, protocol, mid-frame reset, back-to-back and random frames.
module tb_unpatchifier;
    import vit_pkg::*;

    localparam int W      = 16;
    localparam int H      = 16;
    localparam int PS     = 4;
    localparam int NBEATS = 256;

    logic       clk;
    logic       reset;
    logic       en;
    logic       output_taken;
    logic [2:0] state;
    logic       done;
    pixel_t     image_out [W][H];

    unpatchifier_if pix_if ();

    unpatchifier dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .output_taken (output_taken),
        .pix          (pix_if),
        .state        (state),
        .done         (done),
        .image_out    (image_out)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    pixel_t exp_q[$];
    pixel_t exp_img [W][H];
    int     fx;
    int     fy;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Beat b belongs to patch b/16 at position b%16; patches tile the frame row-major.
    task automatic build_model();
        int patch, pos, x, y;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                exp_img[i][j] = '0;
        for (int b = 0; b < exp_q.size(); b++) begin
            patch = b / (PS * PS);
            pos   = b % (PS * PS);
            x     = (patch % (W / PS)) * PS + (pos % PS);
            y     = (patch / (W / PS)) * PS + (pos / PS);
            exp_img[x][y] = exp_q[b];
        end
    endtask

    function automatic int img_diffs(input bit vs_zero);
        int     n;
        pixel_t e;
        n = 0;
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) begin
                e = vs_zero ? '0 : exp_img[x][y];
                if (image_out[x][y] !== e) begin
                    if (n == 0) begin
                        fx = x;
                        fy = y;
                    end
                    n++;
                end
            end
        end
        return n;
    endfunction

    // ---------------- drivers ----------------
    // pattern: 0 ramp, 1 inverted ramp, 2 random. bubble: 0 none, 1 alternate, 2 random.
    // latency counts the first-accept cycle as cycle 1 and the first done-high cycle inclusively.
    task automatic stream_frame(input int pattern, input int bubble, input int n_beats,
                                output int latency, output bit ready_drop);
        int     cyc, b, first, done_cyc;
        bit     v;
        pixel_t d;
        exp_q.delete();
        ready_drop = 1'b0;
        cyc = 0; b = 0; first = -1; done_cyc = -1;
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        while (cyc < 3000) begin
            if (b < n_beats) begin
                case (bubble)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                case (pattern)
                    0:       d = pixel_t'(b);
                    1:       d = pixel_t'(255 - b);
                    default: d = pixel_t'($urandom);
                endcase
                pix_if.pix_valid = v;
                pix_if.pix_data  = d;
            end else begin
                pix_if.pix_valid = 1'b0;
            end
            @(negedge clk);
            if (b < n_beats && pix_if.pix_ready !== 1'b1) ready_drop = 1'b1;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                if (first < 0) first = cyc;
                exp_q.push_back(pix_if.pix_data);
                b++;
            end
            if (n_beats < NBEATS && b >= n_beats) break;
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1 pix_if.pix_valid = 1'b0;
        latency = (done_cyc < 0 || first < 0) ? -1 : done_cyc - first + 1;
    endtask

    task automatic take_frame();
        output_taken = 1'b1;
        @(posedge clk); #1 output_taken = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; en = 1'b0; output_taken = 1'b0;
        pix_if.pix_valid = 1'b0; pix_if.pix_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", pix_if.pix_ready); end
        n_cmp++; if (img_diffs(1'b1) !== 0) begin n_err++; $display("FAIL reset_image: [%0d][%0d]=%0h expected 0", fx, fy, image_out[fx][fy]); end
    endtask

    task automatic test_ramp();
        int lat; bit drop;
        stream_frame(0, 0, NBEATS, lat, drop);
        build_model();
        @(negedge clk);
        n_cmp++; if (lat !== 257) begin n_err++; $display("FAIL ramp_latency: got %0d expected 257", lat); end
        n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL ramp_ready: ready dropped during FILL"); end
        n_cmp++; if (state !== DONE || done !== 1'b1) begin n_err++; $display("FAIL ramp_done: state %0d done %b expected 2/1", state, done); end
        n_cmp++; if (image_out[0][0] !== 24'd0) begin n_err++; $display("FAIL ramp_0_0: got %0d expected 0", image_out[0][0]); end
        n_cmp++; if (image_out[3][3] !== 24'd15) begin n_err++; $display("FAIL ramp_3_3: got %0d expected 15", image_out[3][3]); end
        n_cmp++; if (image_out[4][0] !== 24'd16) begin n_err++; $display("FAIL ramp_4_0: got %0d expected 16", image_out[4][0]); end
        n_cmp++; if (image_out[5][6] !== 24'd89) begin n_err++; $display("FAIL ramp_5_6: got %0d expected 89", image_out[5][6]); end
        n_cmp++; if (image_out[15][15] !== 24'd255) begin n_err++; $display("FAIL ramp_15_15: got %0d expected 255", image_out[15][15]); end
        n_cmp++; if (img_diffs(1'b0) !== 0) begin n_err++; $display("FAIL ramp_image: [%0d][%0d]=%0h expected %0h", fx, fy, image_out[fx][fy], exp_img[fx][fy]); end
    endtask

    task automatic test_take();
        take_frame();
        @(negedge clk);
        n_cmp++; if (state !== IDLE || done !== 1'b0) begin n_err++; $display("FAIL take_idle: state %0d done %b expected 0/0", state, done); end
`ifdef UNPATCHIFIER_CLEAR_ON_TAKE_EN
        n_cmp++; if (img_diffs(1'b1) !== 0) begin n_err++; $display("FAIL take_clear: [%0d][%0d]=%0h expected 0", fx, fy, image_out[fx][fy]); end
`else
        n_cmp++; if (image_out[5][6] !== 24'd89) begin n_err++; $display("FAIL take_hold_5_6: got %0d expected 89", image_out[5][6]); end
        n_cmp++; if (img_diffs(1'b0) !== 0) begin n_err++; $display("FAIL take_hold: [%0d][%0d]=%0h expected %0h", fx, fy, image_out[fx][fy], exp_img[fx][fy]); end
`endif
    endtask

    task automatic test_backpressure();
        int lat; bit drop;
        stream_frame(0, 1, NBEATS, lat, drop);
        build_model();
        @(negedge clk);
        n_cmp++; if (lat !== 512) begin n_err++; $display("FAIL bp_latency: got %0d expected 512", lat); end
        n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL bp_ready: ready dropped during FILL"); end
        n_cmp++; if (image_out[5][6] !== 24'd89) begin n_err++; $display("FAIL bp_5_6: got %0d expected 89", image_out[5][6]); end
        n_cmp++; if (img_diffs(1'b0) !== 0) begin n_err++; $display("FAIL bp_image: [%0d][%0d]=%0h expected %0h", fx, fy, image_out[fx][fy], exp_img[fx][fy]); end
        take_frame();
    endtask

    task automatic test_protocol();
        int lat; bit drop;
        @(posedge clk); #1 en = 1'b1; output_taken = 1'b1;
        @(posedge clk); #1 en = 1'b0; output_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== FILL) begin n_err++; $display("FAIL proto_en_wins: got %0d expected %0d", state, FILL); end
        @(posedge clk); #1 output_taken = 1'b1;
        @(posedge clk); #1 output_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== FILL || done !== 1'b0) begin n_err++; $display("FAIL proto_take_in_fill: state %0d done %b expected 1/0", state, done); end
        stream_frame(0, 0, NBEATS, lat, drop);
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== DONE || done !== 1'b1) begin n_err++; $display("FAIL proto_en_in_done: state %0d done %b expected 2/1", state, done); end
        take_frame();
        @(negedge clk);
        n_cmp++; if (state !== IDLE || done !== 1'b0) begin n_err++; $display("FAIL proto_take: state %0d done %b expected 0/0", state, done); end
    endtask

    task automatic test_reset_mid_frame();
        int lat; bit drop;
        stream_frame(2, 2, 100, lat, drop);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== IDLE || pix_if.pix_ready !== 1'b0) begin n_err++; $display("FAIL midrst_state: state %0d ready %b expected 0/0", state, pix_if.pix_ready); end
        n_cmp++; if (img_diffs(1'b1) !== 0) begin n_err++; $display("FAIL midrst_image: [%0d][%0d]=%0h expected 0", fx, fy, image_out[fx][fy]); end
        stream_frame(2, 0, NBEATS, lat, drop);
        build_model();
        @(negedge clk);
        n_cmp++; if (lat !== 257) begin n_err++; $display("FAIL midrst_latency: got %0d expected 257", lat); end
        n_cmp++; if (img_diffs(1'b0) !== 0) begin n_err++; $display("FAIL midrst_image2: [%0d][%0d]=%0h expected %0h", fx, fy, image_out[fx][fy], exp_img[fx][fy]); end
        take_frame();
    endtask

    task automatic test_back_to_back();
        int lat; bit drop;
        stream_frame(0, 0, NBEATS, lat, drop);
        take_frame();
        stream_frame(1, 0, NBEATS, lat, drop);
        build_model();
        @(negedge clk);
        n_cmp++; if (image_out[5][6] !== 24'd166) begin n_err++; $display("FAIL b2b_5_6: got %0d expected 166", image_out[5][6]); end
        n_cmp++; if (img_diffs(1'b0) !== 0) begin n_err++; $display("FAIL b2b_image: [%0d][%0d]=%0h expected %0h", fx, fy, image_out[fx][fy], exp_img[fx][fy]); end
        take_frame();
    endtask

    task automatic test_random();
        int lat; bit drop;
        for (int f = 0; f < 2; f++) begin
            stream_frame(2, 2, NBEATS, lat, drop);
            build_model();
            @(negedge clk);
            n_cmp++; if (drop !== 1'b0 || lat < 257) begin n_err++; $display("FAIL rand_flow: frame %0d latency %0d drop %b expected >=257/0", f, lat, drop); end
            n_cmp++; if (img_diffs(1'b0) !== 0) begin n_err++; $display("FAIL rand_image: frame %0d [%0d][%0d]=%0h expected %0h", f, fx, fy, image_out[fx][fy], exp_img[fx][fy]); end
            take_frame();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ramp();
        test_take();
        test_backpressure();
        test_protocol();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unpatchifier.md
Name: unpatchifier

Overview:
- Inverse of the patchification stage: reassembles a stream of ViT patch vectors, one pixel per beat, into a full image frame buffer in raster [x][y] layout.
- Sits at the output end of the patch pipeline, for example after decoding or reconstruction, and hands a complete frame downstream.
- Uses the same en / output_taken / state control convention as the patchifier.

Parameters:
- CHANNEL_SIZE, 8, bits per colour channel
- NUM_CHANNELS, 3, channels per pixel (RGB)
- PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, bits per pixel
- IMG_WIDTH, 16, image columns (x)
- IMG_HEIGHT, 16, image rows (y)
- PATCH_SIZE, 4, patch edge length; must be a power of two
- PATCH_SIZE_LOG2, 2, log2(PATCH_SIZE)
- PATCHES_IN_ROW, IMG_WIDTH/PATCH_SIZE, patches per patch-row
- TOTAL_NUM_PATCHES, (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE), patches per frame
- PATCH_VECTOR_SIZE, PATCH_SIZE*PATCH_SIZE, pixels per patch

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- en  input  1  start frame reassembly (sampled in IDLE only)
- output_taken  input  1  consumer has taken the frame (sampled in DONE only)
- pix_valid  input  1  pix_data beat valid
- pix_ready  output  1  block accepts a beat
- pix_data  input  PIXEL_WIDTH  pixel at the current patch/position
- state  output  3  FSM state
- done  output  1  frame complete; image_out stable
- image_out  output  [PIXEL_WIDTH-1:0] x [IMG_WIDTH] x [IMG_HEIGHT]  reassembled frame, indexed [x][y]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and named reset.
- State encoding: IDLE=3'b000, FILL=3'b001, DONE=3'b010. Other codes are unreachable and return to IDLE.
- Transitions:
  - IDLE -> FILL when en=1.
  - FILL -> DONE on the cycle after the last beat is accepted.
  - DONE -> IDLE when output_taken=1.
- en is ignored outside IDLE. output_taken is ignored outside DONE.
- Handshake: pix_ready = (state==FILL), driven from registered state with no combinational path from pix_valid. A beat is accepted when pix_valid && pix_ready.
- Counters:
  - pos_idx runs 0..PATCH_VECTOR_SIZE-1. patch_idx runs 0..TOTAL_NUM_PATCHES-1.
  - pos_idx increments on each accepted beat. It wraps to 0 at PATCH_VECTOR_SIZE-1 and patch_idx then increments.
  - The last beat is patch_idx==TOTAL_NUM_PATCHES-1 && pos_idx==PATCH_VECTOR_SIZE-1. Both counters then wrap to 0.
- Address mapping:
  - prow = patch_idx >> log2(PATCHES_IN_ROW) (PATCHES_IN_ROW is a power of two); pcol = patch_idx & (PATCHES_IN_ROW-1).
  - pr = pos_idx >> PATCH_SIZE_LOG2; pc = pos_idx & (PATCH_SIZE-1).
  - x = pcol*PATCH_SIZE + pc; y = prow*PATCH_SIZE + pr.
  - Write image_out[x][y] <= pix_data on accept. Write latency is 1 cycle.
- Throughput: 1 pixel/cycle. A full frame takes TOTAL_NUM_PATCHES*PATCH_VECTOR_SIZE accepted beats (256 by default). Bubbles (pix_valid=0) stall counters without penalty.
- done = (state==DONE). It stays high until output_taken. image_out holds while in DONE and IDLE.
- Reset values: state=IDLE, done=0, pix_ready=0, counters=0, all image_out entries=0.
- Reset mid-FILL: counters and FSM return to IDLE and image_out is cleared. The partial frame is discarded.
- en and output_taken together in IDLE: en wins, since output_taken is ignored there.
- Counters are always 0 when entering FILL.

Optional Feature:
- Macro: UNPATCHIFIER_CLEAR_ON_TAKE_EN
- Defined: on the DONE->IDLE transition, all image_out entries clear to 0 in the same cycle the state updates.
- Undefined: image_out retains the last frame until overwritten by the next FILL or by reset.

Decomposition:
- Shared package vit_pkg holds:
  - state localparams IDLE/FILL/DONE and a 3-bit state typedef
  - pixel_t typedef (logic [PIXEL_WIDTH-1:0])
  - default geometry constants shared with patchifier
- Sub-module patch_addr_gen: owns pos_idx/patch_idx counters, advances on an accept strobe, and outputs x, y and a last flag. The mapping is reusable by the patchifier's reverse indexing.

Test Plan:
- Ramp: en=1, stream 256 beats with pix_data=beat index, pix_valid always 1.
  - done asserts exactly 257 cycles after the first accept.
  - image_out[0][0]=0, image_out[3][3]=15, image_out[4][0]=16, image_out[5][6]=89, image_out[15][15]=255.
- Back-pressure: same ramp with pix_valid toggling 1/0 each cycle.
  - Identical image_out contents; done after about 512 cycles.
  - pix_ready stays 1 throughout FILL.
- Protocol: output_taken pulsed during FILL -> no effect. en pulsed during DONE -> no effect. output_taken in DONE -> state=IDLE next cycle, done=0.
- Reset mid-frame: reset after 100 beats -> state=IDLE, image_out all 0. A new en plus 256 beats yields a correct full frame.
- Back-to-back frames: frame A = ramp, output_taken, frame B = 255-index -> image_out[5][6]=166.
- Feature:
  - With UNPATCHIFIER_CLEAR_ON_TAKE_EN, image_out is all 0 the cycle after output_taken.
  - Without it, image_out[5][6] stays 89.
